// File: rtl/test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_pkg
// Description : Shared constants and types for the test traffic checker.
// Revision    : 1.0 - initial release
// ============================================================================
package test_pkg;

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] PKT  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_HUNT = HUNT,
        ST_PKT  = PKT,
        ST_GAP  = GAP
    } state_t;

    // Must match the generator seed so both sides produce the same sequence.
    localparam logic [15:0] TEST_SCR_INIT = 16'h55AA;
    localparam int          TEST_CNT_W    = 32;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sata_scrambler.sv
`default_nettype none
// ============================================================================
// Module      : sata_scrambler
// Description : LFSR x^16+x^15+x^13+x^4+1, advanced 8 bits per enabled byte.
// Revision    : 1.0 - initial release
// ============================================================================
module sata_scrambler #(
    parameter logic [15:0] G_INIT_VAL = 16'hF0F6,
    parameter int          G_OUT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               p_in_SOF,
    input  logic               p_in_en,
    output logic [G_OUT_W-1:0] p_out_result
);

    logic [15:0] r_lfsr;

    function automatic logic [15:0] step8(input logic [15:0] l);
        logic [15:0] v;
        v = l;
        for (int i = 0; i < 8; i++) begin
            v = {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || p_in_SOF) begin
            r_lfsr <= G_INIT_VAL;
        end else if (p_in_en) begin
            r_lfsr <= step8(r_lfsr);
        end
    end

    assign p_out_result = r_lfsr[G_OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/test_rx_cnt.sv
`default_nettype none
// ============================================================================
// Module      : test_rx_cnt
// Description : Saturating up-counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module test_rx_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/test_rx.sv
`default_nettype none
// ============================================================================
// Module      : test_rx
// Description : Loopback checker: compares received bytes with a local
//               scrambler, checks lengths, keeps saturating error counters.
//               TEST_RX_FIRST_ERR_EN adds first-mismatch capture outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module test_rx
    import test_pkg::*;
#(
    parameter logic [15:0] G_INIT_VAL = TEST_SCR_INIT,
    parameter int          G_CNT_W    = TEST_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         mac_rx_data,
    input  logic               mac_rx_valid,
    input  logic               mac_rx_sof,
    input  logic               mac_rx_eof,
    input  logic [15:0]        pkt_size,
    input  logic               clr,
    output logic               locked,
    output logic [G_CNT_W-1:0] pkt_cnt,
    output logic [G_CNT_W-1:0] pkt_err_cnt,
    output logic [G_CNT_W-1:0] byte_err_cnt,
    output logic [15:0]        len_err_cnt,
    output logic               err
`ifdef TEST_RX_FIRST_ERR_EN
    ,
    output logic [15:0]        first_err_idx,
    output logic [G_CNT_W-1:0] first_err_pkt,
    output logic [7:0]         first_err_exp,
    output logic [7:0]         first_err_rcv
`endif
);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_idx, r_size;
    logic        r_perr, r_locked, r_err;

    logic [7:0]  w_exp;
    logic        w_start, w_in_pkt, w_active, w_mismatch;
    logic [15:0] w_idx_cur, w_size_cur;
    logic        w_close_sof, w_close_eof, w_len_err, w_perr_cur;
    logic        w_inc_pkt, w_inc_pkt_err;

    assign w_start     = mac_rx_valid && mac_rx_sof;
    assign w_in_pkt    = (r_state == ST_PKT);
    assign w_active    = mac_rx_valid && ((r_state != ST_HUNT) || mac_rx_sof);
    assign w_mismatch  = w_active && (mac_rx_data != w_exp);
    assign w_idx_cur   = w_start ? 16'd1 : sat_inc16(r_idx);
    assign w_size_cur  = w_start ? pkt_size : r_size;
    // A sof inside a packet closes the old one as errored, with no length check.
    assign w_close_sof = w_in_pkt && w_start;
    assign w_close_eof = mac_rx_valid && mac_rx_eof && (w_in_pkt != mac_rx_sof);
    assign w_len_err   = w_close_eof && (w_idx_cur != w_size_cur);
    assign w_perr_cur  = (w_start ? 1'b0 : r_perr) || w_mismatch;
    assign w_inc_pkt     = w_close_sof || w_close_eof;
    assign w_inc_pkt_err = w_close_sof || (w_close_eof && (w_perr_cur || w_len_err));

    // Scrambler also restarts on clr so a sof right after clr sees the seed.
    sata_scrambler #(
        .G_INIT_VAL (G_INIT_VAL),
        .G_OUT_W    (8)
    ) u_scr (
        .clk          (clk),
        .rst          (rst || clr),
        .p_in_SOF     ((r_state == ST_HUNT) && !w_start),
        .p_in_en      (w_active),
        .p_out_result (w_exp)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT, ST_GAP: begin
                if (w_start) w_state_nxt = mac_rx_eof ? ST_GAP : ST_PKT;
            end
            ST_PKT: begin
                if (w_start) begin
                    w_state_nxt = mac_rx_eof ? ST_GAP : ST_PKT;
                end else if (mac_rx_valid && mac_rx_eof) begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state  <= ST_HUNT;
            r_idx    <= 16'd0;
            r_size   <= 16'd0;
            r_perr   <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_locked <= 1'b1;
                r_size   <= pkt_size;
            end
            if (w_active && (w_start || w_in_pkt)) begin
                r_idx  <= w_idx_cur;
                r_perr <= w_perr_cur;
            end
            r_err <= r_err || w_inc_pkt_err || w_mismatch || w_len_err;
        end
    end

    test_rx_cnt #(.WIDTH(G_CNT_W)) u_pkt_cnt (
        .clk (clk), .rst (rst), .clr (clr), .inc (w_inc_pkt), .cnt (pkt_cnt));
    test_rx_cnt #(.WIDTH(G_CNT_W)) u_pkt_err_cnt (
        .clk (clk), .rst (rst), .clr (clr), .inc (w_inc_pkt_err), .cnt (pkt_err_cnt));
    test_rx_cnt #(.WIDTH(G_CNT_W)) u_byte_err_cnt (
        .clk (clk), .rst (rst), .clr (clr), .inc (w_mismatch), .cnt (byte_err_cnt));
    test_rx_cnt #(.WIDTH(16)) u_len_err_cnt (
        .clk (clk), .rst (rst), .clr (clr), .inc (w_len_err), .cnt (len_err_cnt));

    assign locked = r_locked;
    assign err    = r_err;

`ifdef TEST_RX_FIRST_ERR_EN
    logic               r_fe_done;
    logic [15:0]        r_fe_idx;
    logic [G_CNT_W-1:0] r_fe_pkt;
    logic [7:0]         r_fe_exp, r_fe_rcv;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_fe_done <= 1'b0;
            r_fe_idx  <= 16'd0;
            r_fe_pkt  <= '0;
            r_fe_exp  <= 8'd0;
            r_fe_rcv  <= 8'd0;
        end else if (w_mismatch && !r_fe_done) begin
            r_fe_done <= 1'b1;
            r_fe_idx  <= w_idx_cur;
            r_fe_pkt  <= pkt_cnt;
            r_fe_exp  <= w_exp;
            r_fe_rcv  <= mac_rx_data;
        end
    end

    assign first_err_idx = r_fe_idx;
    assign first_err_pkt = r_fe_pkt;
    assign first_err_exp = r_fe_exp;
    assign first_err_rcv = r_fe_rcv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_test_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_rx
// Description : Self-checking bench for test_rx (32-bit and 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_rx;

    logic        clk = 1'b0;
    logic        rst, clr, valid, sof, eof;
    logic [7:0]  data;
    logic [15:0] pkt_size;

    logic        locked, err, locked_s, err_s;
    logic [31:0] pkt_cnt, pkt_err_cnt, byte_err_cnt;
    logic [3:0]  pkt_cnt_s, pkt_err_cnt_s, byte_err_cnt_s;
    logic [15:0] len_err_cnt, len_err_cnt_s;
`ifdef TEST_RX_FIRST_ERR_EN
    logic [15:0] fe_idx, fe_idx_s;
    logic [31:0] fe_pkt;
    logic [3:0]  fe_pkt_s;
    logic [7:0]  fe_exp, fe_rcv, fe_exp_s, fe_rcv_s;
`endif

    always #5 clk = ~clk;

    test_rx #(.G_INIT_VAL(16'h55AA), .G_CNT_W(32)) dut (
        .clk (clk), .rst (rst), .mac_rx_data (data), .mac_rx_valid (valid),
        .mac_rx_sof (sof), .mac_rx_eof (eof), .pkt_size (pkt_size), .clr (clr),
        .locked (locked), .pkt_cnt (pkt_cnt), .pkt_err_cnt (pkt_err_cnt),
        .byte_err_cnt (byte_err_cnt), .len_err_cnt (len_err_cnt), .err (err)
`ifdef TEST_RX_FIRST_ERR_EN
        , .first_err_idx (fe_idx), .first_err_pkt (fe_pkt),
        .first_err_exp (fe_exp), .first_err_rcv (fe_rcv)
`endif
    );

    test_rx #(.G_INIT_VAL(16'h55AA), .G_CNT_W(4)) dut_s (
        .clk (clk), .rst (rst), .mac_rx_data (data), .mac_rx_valid (valid),
        .mac_rx_sof (sof), .mac_rx_eof (eof), .pkt_size (pkt_size), .clr (clr),
        .locked (locked_s), .pkt_cnt (pkt_cnt_s), .pkt_err_cnt (pkt_err_cnt_s),
        .byte_err_cnt (byte_err_cnt_s), .len_err_cnt (len_err_cnt_s), .err (err_s)
`ifdef TEST_RX_FIRST_ERR_EN
        , .first_err_idx (fe_idx_s), .first_err_pkt (fe_pkt_s),
        .first_err_exp (fe_exp_s), .first_err_rcv (fe_rcv_s)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: generator sequence plus packet-level bookkeeping.
    int unsigned m_pkt, m_pkterr, m_byte, m_len;
    bit          m_err, m_locked, m_open;
    int unsigned g_lfsr;
    bit          m_fe_done;
    int unsigned m_fe_idx, m_fe_pkt, m_fe_exp, m_fe_rcv;

    function automatic int unsigned gen_next(input int unsigned l);
        int unsigned v, fb;
        v = l;
        for (int i = 0; i < 8; i++) begin
            fb = ((v >> 15) ^ (v >> 14) ^ (v >> 12) ^ (v >> 3)) & 1;
            v  = ((v << 1) | fb) & 32'hFFFF;
        end
        return v;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pkt = 0; m_pkterr = 0; m_byte = 0; m_len = 0;
        m_err = 0; m_locked = 0; m_open = 0; g_lfsr = 32'h55AA;
        m_fe_done = 0; m_fe_idx = 0; m_fe_pkt = 0; m_fe_exp = 0; m_fe_rcv = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pkt_cnt"},      pkt_cnt,      m_pkt);
        chk({tag, ".pkt_err_cnt"},  pkt_err_cnt,  m_pkterr);
        chk({tag, ".byte_err_cnt"}, byte_err_cnt, m_byte);
        chk({tag, ".len_err_cnt"},  len_err_cnt,  m_len);
        chk({tag, ".locked"},       locked,       m_locked);
        chk({tag, ".err"},          err,          m_err);
        chk({tag, ".s_pkt_cnt"},    pkt_cnt_s,      sat(m_pkt, 4));
        chk({tag, ".s_pkt_err"},    pkt_err_cnt_s,  sat(m_pkterr, 4));
        chk({tag, ".s_byte_err"},   byte_err_cnt_s, sat(m_byte, 4));
        chk({tag, ".s_err"},        err_s,          m_err);
`ifdef TEST_RX_FIRST_ERR_EN
        chk({tag, ".fe_idx"}, fe_idx, m_fe_idx);
        chk({tag, ".fe_pkt"}, fe_pkt, m_fe_pkt);
        chk({tag, ".fe_exp"}, fe_exp, m_fe_exp);
        chk({tag, ".fe_rcv"}, fe_rcv, m_fe_rcv);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid = 1'b0; sof = 1'($urandom); eof = 1'($urandom); data = 8'($urandom);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        if ($urandom_range(3) == 0) idle(1);
        @(posedge clk); #1;
        valid = 1'b1; data = d; sof = s; eof = e;
    endtask

    task automatic note_byte_err(input int unsigned idx, input int unsigned exp, input int unsigned rcv);
        m_byte++; m_err = 1;
        if (!m_fe_done) begin
            m_fe_done = 1; m_fe_idx = idx; m_fe_pkt = m_pkt; m_fe_exp = exp; m_fe_rcv = rcv;
        end
    endtask

    task automatic send_pkt(input int len, input int size, input int flip_pos,
                            input bit flip_all, input bit no_eof);
        bit perr, lerr;
        int unsigned e, d;
        pkt_size = 16'(size);
        if (m_open) begin
            m_pkt++; m_pkterr++; m_err = 1;
        end
        m_locked = 1; perr = 0;
        for (int i = 0; i < len; i++) begin
            e = g_lfsr & 8'hFF;
            d = e;
            if (flip_all || i == flip_pos) d = e ^ $urandom_range(1, 255);
            if (d != e) begin
                perr = 1;
                note_byte_err(i + 1, e, d);
            end
            send_byte(8'(d), i == 0, (i == len - 1) && !no_eof);
            g_lfsr = gen_next(g_lfsr);
        end
        if (no_eof) begin
            m_open = 1;
        end else begin
            m_open = 0; m_pkt++;
            lerr = (len != size);
            if (lerr) m_len++;
            if (perr || lerr) begin
                m_pkterr++; m_err = 1;
            end
        end
    endtask

    initial begin
        int len, size, fp;
        int unsigned e, d;
        rst = 1'b1; clr = 1'b0; valid = 1'b0; sof = 1'b0; eof = 1'b0;
        data = 8'h00; pkt_size = 16'd64;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        check_all("reset");

        // Unframed bytes while hunting are ignored.
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'($urandom));
        idle(3);
        check_all("hunt");

        for (int p = 0; p < 100; p++) begin
            send_pkt(64, 64, -1, 0, 0);
            idle(16);
        end
        check_all("clean100");

        send_pkt(64, 64, $urandom_range(1, 62), 0, 0);
        idle(4);
        check_all("byteflip");

        send_pkt(60, 64, -1, 0, 0);
        idle(4);
        check_all("trunc");

        send_pkt(30, 64, -1, 0, 1);
        send_pkt(64, 64, -1, 0, 0);
        idle(4);
        check_all("midsof");

        // Stray byte in GAP: counted only if it mismatches.
        e = g_lfsr & 8'hFF;
        d = $urandom_range(0, 1) ? e : (e ^ 8'h5A);
        if (d != e) note_byte_err(0, e, d);
        send_byte(8'(d), 1'b0, 1'b0);
        g_lfsr = gen_next(g_lfsr);
        idle(3);
        check_all("gapbyte");

        send_pkt(1, 2, -1, 0, 0);
        idle(3);
        check_all("onebyte");

        for (int p = 0; p < 12; p++) begin
            len  = $urandom_range(2, 80);
            size = $urandom_range(0, 1) ? len : $urandom_range(2, 80);
            fp   = ($urandom_range(3) == 0) ? $urandom_range(0, len - 1) : -1;
            send_pkt(len, size, fp, 0, 0);
            idle($urandom_range(0, 5));
        end
        idle(3);
        check_all("random");

        send_pkt(20, 20, -1, 1, 0);
        idle(3);
        check_all("saturate");

        // clr mid-packet, then restart from the seed.
        send_pkt(20, 64, -1, 0, 1);
        @(posedge clk); #1;
        valid = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_reset();
        idle(2);
        check_all("clr");

        for (int p = 0; p < 20; p++) begin
            send_pkt(64, 64, -1, 0, 0);
            idle(16);
        end
        check_all("relock20");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
